axil_reg_master: RTL and testbench

Single-outstanding AXI4-Lite master engine that executes one register write or read per command and returns the response. It sits directly downstream of the MM2S/S2MM register-programming controllers: they issue (address, data, write/read) commands, and this block drives the `m_axi_lite_*` bus into the AXI DMA register file. It also returns read data, so controllers can poll DMASR.

---
 rtl/axil_reg_master_if.sv | 77 +++++++
 rtl/axil_reg_master.sv | 243 ++++++++++++++++++++++++
 tb/tb_axil_reg_master.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_reg_master_if.sv
// axil_reg_master_if
//   Bundles the command/response handshake of the register master together
//   with its AXI4-Lite master bus.
//   Ports (signals):
//     cmd_*  : command request (valid/ready/write/addr/wdata)
//     rsp_*  : response (valid/ready/rdata/resp/timeout)
//     m_axi_lite_* : AW, W, B, AR, R channels
//   Modports:
//     master : view of the axil_reg_master engine
//     slave  : view of the environment (controllers + AXI-Lite register file)
interface axil_reg_master_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_resp;
  logic              rsp_timeout;

  logic [ADDR_W-1:0] m_axi_lite_awaddr;
  logic              m_axi_lite_awvalid;
  logic              m_axi_lite_awready;
  logic [DATA_W-1:0] m_axi_lite_wdata;
  logic              m_axi_lite_wvalid;
  logic              m_axi_lite_wready;
  logic [1:0]        m_axi_lite_bresp;
  logic              m_axi_lite_bvalid;
  logic              m_axi_lite_bready;
  logic [ADDR_W-1:0] m_axi_lite_araddr;
  logic              m_axi_lite_arvalid;
  logic              m_axi_lite_arready;
  logic [DATA_W-1:0] m_axi_lite_rdata;
  logic [1:0]        m_axi_lite_rresp;
  logic              m_axi_lite_rvalid;
  logic              m_axi_lite_rready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    input  rsp_ready,
    output m_axi_lite_awaddr, m_axi_lite_awvalid,
    input  m_axi_lite_awready,
    output m_axi_lite_wdata, m_axi_lite_wvalid,
    input  m_axi_lite_wready,
    input  m_axi_lite_bresp, m_axi_lite_bvalid,
    output m_axi_lite_bready,
    output m_axi_lite_araddr, m_axi_lite_arvalid,
    input  m_axi_lite_arready,
    input  m_axi_lite_rdata, m_axi_lite_rresp, m_axi_lite_rvalid,
    output m_axi_lite_rready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    output rsp_ready,
    input  m_axi_lite_awaddr, m_axi_lite_awvalid,
    output m_axi_lite_awready,
    input  m_axi_lite_wdata, m_axi_lite_wvalid,
    output m_axi_lite_wready,
    output m_axi_lite_bresp, m_axi_lite_bvalid,
    input  m_axi_lite_bready,
    input  m_axi_lite_araddr, m_axi_lite_arvalid,
    output m_axi_lite_arready,
    output m_axi_lite_rdata, m_axi_lite_rresp, m_axi_lite_rvalid,
    input  m_axi_lite_rready
  );
endinterface

// File: rtl/axil_reg_master.sv
// axil_reg_master
//   Single-outstanding AXI4-Lite master: executes one register write or read
//   per accepted command and returns BRESP/RRESP plus read data.
//   Ports:
//     clk  : clock
//     rst  : synchronous, active-high reset
//     bus  : axil_reg_master_if.master (cmd_*, rsp_*, m_axi_lite_*)
//   Parameters:
//     ADDR_W  : AXI-Lite address width
//     DATA_W  : data width
//     TIMEOUT : cycles allowed per transaction before abort (0 = never)
module axil_reg_master #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input logic               clk,
  input logic               rst,
  axil_reg_master_if.master bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RESP    = 3'd5
  } state_t;

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);
  localparam logic        TIMEOUT_EN  = (TIMEOUT != 0);

  state_t            state_r,       state_s;
  logic [15:0]       cnt_r,         cnt_s;
  logic [ADDR_W-1:0] addr_r,        addr_s;
  logic [DATA_W-1:0] wdata_r,       wdata_s;
  logic              awvalid_r,     awvalid_s;
  logic              wvalid_r,      wvalid_s;
  logic              bready_r,      bready_s;
  logic              arvalid_r,     arvalid_s;
  logic              rready_r,      rready_s;
  logic              rsp_valid_r,   rsp_valid_s;
  logic [DATA_W-1:0] rsp_rdata_r,   rsp_rdata_s;
  logic [1:0]        rsp_resp_r,    rsp_resp_s;
  logic              rsp_timeout_r, rsp_timeout_s;

  logic              busy_s;
  logic              abort_s;
  logic              aw_done_s;
  logic              w_done_s;

  // State and output registers; every bus-facing output comes from here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      cnt_r         <= 16'd0;
      addr_r        <= '0;
      wdata_r       <= '0;
      awvalid_r     <= 1'b0;
      wvalid_r      <= 1'b0;
      bready_r      <= 1'b0;
      arvalid_r     <= 1'b0;
      rready_r      <= 1'b0;
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= '0;
      rsp_resp_r    <= 2'b00;
      rsp_timeout_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      addr_r        <= addr_s;
      wdata_r       <= wdata_s;
      awvalid_r     <= awvalid_s;
      wvalid_r      <= wvalid_s;
      bready_r      <= bready_s;
      arvalid_r     <= arvalid_s;
      rready_r      <= rready_s;
      rsp_valid_r   <= rsp_valid_s;
      rsp_rdata_r   <= rsp_rdata_s;
      rsp_resp_r    <= rsp_resp_s;
      rsp_timeout_r <= rsp_timeout_s;
    end
  end

  // Next-state and next-output logic for the transaction FSM.
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    addr_s        = addr_r;
    wdata_s       = wdata_r;
    awvalid_s     = awvalid_r;
    wvalid_s      = wvalid_r;
    bready_s      = bready_r;
    arvalid_s     = arvalid_r;
    rready_s      = rready_r;
    rsp_valid_s   = rsp_valid_r;
    rsp_rdata_s   = rsp_rdata_r;
    rsp_resp_s    = rsp_resp_r;
    rsp_timeout_s = rsp_timeout_r;

    busy_s  = (state_r == WR_REQ) || (state_r == WR_RESP) ||
              (state_r == RD_REQ) || (state_r == RD_DATA);
    abort_s = busy_s && TIMEOUT_EN && (cnt_r == TIMEOUT_CNT);

    // A channel counts as done once its valid has already dropped, or when
    // its handshake happens this cycle; this lets AW and W finish in any order.
    aw_done_s = !awvalid_r || bus.m_axi_lite_awready;
    w_done_s  = !wvalid_r  || bus.m_axi_lite_wready;

    if (abort_s) begin
      // Debug escape: abandon the bus mid-transaction. Any late B/R beat is
      // ignored because bready/rready are already low by then.
      awvalid_s     = 1'b0;
      wvalid_s      = 1'b0;
      bready_s      = 1'b0;
      arvalid_s     = 1'b0;
      rready_s      = 1'b0;
      rsp_valid_s   = 1'b1;
      rsp_rdata_s   = '0;
      rsp_resp_s    = 2'b10;
      rsp_timeout_s = 1'b1;
      state_s       = RESP;
    end else begin
      if (busy_s) begin
        cnt_s = (cnt_r == 16'hFFFF) ? cnt_r : (cnt_r + 16'd1);
      end else begin
        cnt_s = cnt_r;
      end

      case (state_r)
        IDLE: begin
          if (bus.cmd_valid) begin
            addr_s  = bus.cmd_addr;
            wdata_s = bus.cmd_wdata;
            cnt_s   = 16'd0;
            if (bus.cmd_write) begin
              awvalid_s = 1'b1;
              wvalid_s  = 1'b1;
              state_s   = WR_REQ;
            end else begin
              arvalid_s = 1'b1;
              state_s   = RD_REQ;
            end
          end else begin
            state_s = IDLE;
          end
        end

        WR_REQ: begin
          if (awvalid_r && bus.m_axi_lite_awready) begin
            awvalid_s = 1'b0;
          end else begin
            awvalid_s = awvalid_r;
          end
          if (wvalid_r && bus.m_axi_lite_wready) begin
            wvalid_s = 1'b0;
          end else begin
            wvalid_s = wvalid_r;
          end
          if (aw_done_s && w_done_s) begin
            bready_s = 1'b1;
            state_s  = WR_RESP;
          end else begin
            state_s = WR_REQ;
          end
        end

        WR_RESP: begin
          if (bus.m_axi_lite_bvalid) begin
            bready_s      = 1'b0;
            rsp_valid_s   = 1'b1;
            rsp_rdata_s   = '0;
            rsp_resp_s    = bus.m_axi_lite_bresp;
            rsp_timeout_s = 1'b0;
            state_s       = RESP;
          end else begin
            state_s = WR_RESP;
          end
        end

        RD_REQ: begin
          if (bus.m_axi_lite_arready) begin
            arvalid_s = 1'b0;
            rready_s  = 1'b1;
            state_s   = RD_DATA;
          end else begin
            state_s = RD_REQ;
          end
        end

        RD_DATA: begin
          if (bus.m_axi_lite_rvalid) begin
            rready_s      = 1'b0;
            rsp_valid_s   = 1'b1;
            rsp_rdata_s   = bus.m_axi_lite_rdata;
            rsp_resp_s    = bus.m_axi_lite_rresp;
            rsp_timeout_s = 1'b0;
            state_s       = RESP;
          end else begin
            state_s = RD_DATA;
          end
        end

        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_s = 1'b0;
            state_s     = IDLE;
          end else begin
            state_s = RESP;
          end
        end

        default: begin
          awvalid_s   = 1'b0;
          wvalid_s    = 1'b0;
          bready_s    = 1'b0;
          arvalid_s   = 1'b0;
          rready_s    = 1'b0;
          rsp_valid_s = 1'b0;
          state_s     = IDLE;
        end
      endcase
    end
  end

  // Bus outputs: addresses and data come from the latched command, so they
  // cannot move while the matching valid is high.
  assign bus.cmd_ready          = (state_r == IDLE);
  assign bus.rsp_valid          = rsp_valid_r;
  assign bus.rsp_rdata          = rsp_rdata_r;
  assign bus.rsp_resp           = rsp_resp_r;
  assign bus.rsp_timeout        = rsp_timeout_r;
  assign bus.m_axi_lite_awaddr  = addr_r;
  assign bus.m_axi_lite_awvalid = awvalid_r;
  assign bus.m_axi_lite_wdata   = wdata_r;
  assign bus.m_axi_lite_wvalid  = wvalid_r;
  assign bus.m_axi_lite_bready  = bready_r;
  assign bus.m_axi_lite_araddr  = addr_r;
  assign bus.m_axi_lite_arvalid = arvalid_r;
  assign bus.m_axi_lite_rready  = rready_r;

endmodule

// File: tb/tb_axil_reg_master.sv
// tb_axil_reg_master
//   Directed bench for axil_reg_master. Stimulus pushes the expected response
//   of each command into a queue; a monitor pops and compares it at every
//   rsp_valid & rsp_ready handshake. Bus-timing checks sit in the stimulus.
module tb_axil_reg_master;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  axil_reg_master_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  axil_reg_master #(
    .ADDR_W (10),
    .DATA_W (32),
    .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        to;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Slave knobs
  int          aw_delay = 0;
  int          w_delay  = 0;
  int          ar_delay = 0;
  int          r_delay  = 0;
  logic        b_tie    = 1'b1;
  logic [1:0]  bresp_v  = 2'b00;
  logic [31:0] rdata_v  = 32'h0;
  logic [1:0]  rresp_v  = 2'b00;

  int   aw_wait = 0;
  int   w_wait  = 0;
  int   ar_wait = 0;
  int   r_wait  = 0;
  logic r_pend  = 1'b0;

  // Wait counters: count cycles a valid has been waiting for its ready.
  always @(posedge clk) begin
    if (rst || !bus.m_axi_lite_awvalid || bus.m_axi_lite_awready) aw_wait <= 0;
    else aw_wait <= aw_wait + 1;
    if (rst || !bus.m_axi_lite_wvalid || bus.m_axi_lite_wready) w_wait <= 0;
    else w_wait <= w_wait + 1;
    if (rst || !bus.m_axi_lite_arvalid || bus.m_axi_lite_arready) ar_wait <= 0;
    else ar_wait <= ar_wait + 1;
    if (rst) begin
      r_pend <= 1'b0;
      r_wait <= 0;
    end else if (bus.m_axi_lite_arvalid && bus.m_axi_lite_arready) begin
      r_pend <= 1'b1;
      r_wait <= 0;
    end else if (bus.m_axi_lite_rvalid && bus.m_axi_lite_rready) begin
      r_pend <= 1'b0;
    end else if (r_pend) begin
      r_wait <= r_wait + 1;
    end
  end

  assign bus.m_axi_lite_awready = bus.m_axi_lite_awvalid && (aw_wait >= aw_delay);
  assign bus.m_axi_lite_wready  = bus.m_axi_lite_wvalid  && (w_wait  >= w_delay);
  assign bus.m_axi_lite_bvalid  = b_tie;
  assign bus.m_axi_lite_bresp   = bresp_v;
  assign bus.m_axi_lite_arready = bus.m_axi_lite_arvalid && (ar_wait >= ar_delay);
  assign bus.m_axi_lite_rvalid  = r_pend && (r_wait >= r_delay);
  assign bus.m_axi_lite_rdata   = rdata_v;
  assign bus.m_axi_lite_rresp   = rresp_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Response monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_unexpected: got a response, expected none");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_rdata",   bus.rsp_rdata,          e.rdata);
        check("rsp_resp",    {30'd0, bus.rsp_resp},  {30'd0, e.resp});
        check("rsp_timeout", {31'd0, bus.rsp_timeout}, {31'd0, e.to});
      end
    end
  end

  // Present a command; returns #1 after the accepting edge (start of cycle 1).
  task automatic issue(input logic wr, input logic [9:0] a, input logic [31:0] d, input exp_t e);
    int n;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL cmd_accept: got cmd_ready=0, expected 1 within 50 cycles");
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.cmd_ready && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 10'd0;
    bus.cmd_wdata = 32'd0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_cmd_ready",   {31'd0, bus.cmd_ready},          32'd1);
    check("rst_rsp_valid",   {31'd0, bus.rsp_valid},          32'd0);
    check("rst_awvalid",     {31'd0, bus.m_axi_lite_awvalid}, 32'd0);
    check("rst_wvalid",      {31'd0, bus.m_axi_lite_wvalid},  32'd0);
    check("rst_arvalid",     {31'd0, bus.m_axi_lite_arvalid}, 32'd0);
    check("rst_bready",      {31'd0, bus.m_axi_lite_bready},  32'd0);
    check("rst_rready",      {31'd0, bus.m_axi_lite_rready},  32'd0);
    check("rst_rsp_rdata",   bus.rsp_rdata,                   32'd0);
    check("rst_rsp_resp",    {30'd0, bus.rsp_resp},           32'd0);
    check("rst_rsp_timeout", {31'd0, bus.rsp_timeout},        32'd0);
    check("rst_awaddr",      {22'd0, bus.m_axi_lite_awaddr},  32'd0);

    // 1: zero-wait write 0x18 <- 0x1000_0000
    e = '{rdata: 32'd0, resp: 2'b00, to: 1'b0};
    issue(1'b1, 10'h018, 32'h1000_0000, e);
    @(negedge clk);
    check("w1_awvalid_c1", {31'd0, bus.m_axi_lite_awvalid}, 32'd1);
    check("w1_wvalid_c1",  {31'd0, bus.m_axi_lite_wvalid},  32'd1);
    check("w1_awaddr",     {22'd0, bus.m_axi_lite_awaddr},  32'h018);
    check("w1_wdata",      bus.m_axi_lite_wdata,            32'h1000_0000);
    @(negedge clk);
    check("w1_awvalid_c2", {31'd0, bus.m_axi_lite_awvalid}, 32'd0);
    check("w1_wvalid_c2",  {31'd0, bus.m_axi_lite_wvalid},  32'd0);
    check("w1_bready_c2",  {31'd0, bus.m_axi_lite_bready},  32'd1);
    check("w1_rsp_valid_c2", {31'd0, bus.rsp_valid},        32'd0);
    @(negedge clk);
    check("w1_rsp_valid_c3", {31'd0, bus.rsp_valid},        32'd1);
    @(negedge clk);
    check("w1_cmd_ready_c4", {31'd0, bus.cmd_ready},        32'd1);
    wait_idle("w1_idle");

    // 2: skewed write, W first then AW four cycles later
    w_delay  = 1;
    aw_delay = 5;
    e = '{rdata: 32'd0, resp: 2'b00, to: 1'b0};
    issue(1'b1, 10'h030, 32'hA5A5_0001, e);
    @(negedge clk);
    @(negedge clk);
    check("w2_wvalid_c2",  {31'd0, bus.m_axi_lite_wvalid},  32'd1);
    check("w2_awvalid_c2", {31'd0, bus.m_axi_lite_awvalid}, 32'd1);
    for (int c = 3; c <= 6; c++) begin
      @(negedge clk);
      check("w2_wvalid_low",   {31'd0, bus.m_axi_lite_wvalid},  32'd0);
      check("w2_awvalid_held", {31'd0, bus.m_axi_lite_awvalid}, 32'd1);
      check("w2_bready_low",   {31'd0, bus.m_axi_lite_bready},  32'd0);
    end
    @(negedge clk);
    check("w2_awvalid_c7", {31'd0, bus.m_axi_lite_awvalid}, 32'd0);
    check("w2_bready_c7",  {31'd0, bus.m_axi_lite_bready},  32'd1);
    wait_idle("w2_idle");
    w_delay  = 0;
    aw_delay = 0;

    // 3: read 0x04 with two wait cycles on AR and R
    ar_delay = 2;
    r_delay  = 2;
    rdata_v  = 32'h0001_1002;
    e = '{rdata: 32'h0001_1002, resp: 2'b00, to: 1'b0};
    issue(1'b0, 10'h004, 32'hDEAD_BEEF, e);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("r3_arvalid_held", {31'd0, bus.m_axi_lite_arvalid}, 32'd1);
      check("r3_araddr",       {22'd0, bus.m_axi_lite_araddr},  32'h004);
    end
    @(negedge clk);
    check("r3_arvalid_c4", {31'd0, bus.m_axi_lite_arvalid}, 32'd0);
    check("r3_rready_c4",  {31'd0, bus.m_axi_lite_rready},  32'd1);
    wait_idle("r3_idle");
    ar_delay = 0;
    r_delay  = 0;

    // 4: SLVERR write, response held while rsp_ready is low
    bresp_v = 2'b10;
    bus.rsp_ready = 1'b0;
    e = '{rdata: 32'd0, resp: 2'b10, to: 1'b0};
    issue(1'b1, 10'h000, 32'h0000_0001, e);
    @(negedge clk);
    @(negedge clk);
    for (int c = 3; c <= 7; c++) begin
      @(negedge clk);
      check("w4_rsp_valid_hold", {31'd0, bus.rsp_valid}, 32'd1);
      check("w4_rsp_resp_hold",  {30'd0, bus.rsp_resp},  32'd2);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("w4_rsp_valid_c8", {31'd0, bus.rsp_valid}, 32'd1);
    @(negedge clk);
    check("w4_rsp_valid_c9", {31'd0, bus.rsp_valid}, 32'd0);
    wait_idle("w4_idle");
    bresp_v = 2'b00;

    // 5: timeout with awready never asserted (TIMEOUT = 16)
    aw_delay = 1000;
    e = '{rdata: 32'd0, resp: 2'b10, to: 1'b1};
    issue(1'b1, 10'h010, 32'h0000_00FF, e);
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      check("t5_awvalid_held", {31'd0, bus.m_axi_lite_awvalid}, 32'd1);
    end
    @(negedge clk);
    check("t5_awvalid_drop", {31'd0, bus.m_axi_lite_awvalid}, 32'd0);
    check("t5_wvalid_drop",  {31'd0, bus.m_axi_lite_wvalid},  32'd0);
    check("t5_rsp_valid",    {31'd0, bus.rsp_valid},          32'd1);
    check("t5_rsp_timeout",  {31'd0, bus.rsp_timeout},        32'd1);
    wait_idle("t5_idle");
    aw_delay = 0;

    // 6: reset while waiting in WR_RESP, then a clean write
    b_tie = 1'b0;
    e = '{rdata: 32'd0, resp: 2'b00, to: 1'b0};
    issue(1'b1, 10'h020, 32'h1234_5678, e);
    @(negedge clk);
    @(negedge clk);
    check("x6_bready_c2", {31'd0, bus.m_axi_lite_bready}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("x6_cmd_ready", {31'd0, bus.cmd_ready},          32'd1);
    check("x6_bready",    {31'd0, bus.m_axi_lite_bready},  32'd0);
    check("x6_awvalid",   {31'd0, bus.m_axi_lite_awvalid}, 32'd0);
    check("x6_rsp_valid", {31'd0, bus.rsp_valid},          32'd0);
    check("x6_awaddr",    {22'd0, bus.m_axi_lite_awaddr},  32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst   = 1'b0;
    b_tie = 1'b1;
    e = '{rdata: 32'd0, resp: 2'b00, to: 1'b0};
    issue(1'b1, 10'h024, 32'h0BAD_F00D, e);
    wait_idle("x6_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
